// File: rtl/data_memory_ls_if.sv
// Request/response bus of the load/store data memory.
// The master issues sized loads and stores; the slave answers each accepted request once, in order.
interface data_memory_ls_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_funct3, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_memory_ls.sv
// Synchronous data memory with RISC-V byte/half/word load-store sizing, error flagging,
// fixed-latency in-order responses and an optional post-reset clearing sweep.
module data_memory_ls #(
    parameter int unsigned DEPTH_WORDS    = 128,
    parameter int unsigned READ_LATENCY   = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    data_memory_ls_if.slave mem_if
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [IDX_W-1:0]   clr_idx_q;
    logic [IDX_W-1:0]   clr_idx_d;
    logic               req_ready_s;
    logic               clr_we_s;

    logic [31:0]        mem_q [DEPTH_WORDS];

    logic               fire_s;
    logic [1:0]         lane_s;
    logic [IDX_W-1:0]   idx_s;
    logic               legal_s;
    logic               misalign_s;
    logic               out_of_range_s;
    logic               err_s;
    logic               wr_en_s;
    logic [3:0]         be_s;
    logic [31:0]        wdata_rep_s;
    logic [31:0]        rd_word_s;
    logic [7:0]         rd_byte_s;
    logic [15:0]        rd_half_s;
    logic [31:0]        ext_s;
    logic [31:0]        load_data_s;

    logic [READ_LATENCY-1:0] rsp_valid_q;
    logic [READ_LATENCY-1:0] rsp_err_q;
    logic [31:0]             rsp_data_q [READ_LATENCY];

    // FSM state register and sweep index
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= CLEAR_ON_RESET ? ST_INIT : ST_READY;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // FSM next-state: sweep every word once, then serve requests
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_INIT: begin
                clr_idx_d = clr_idx_q + IDX_W'(1);
                if (clr_idx_q == IDX_W'(DEPTH_WORDS - 1)) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    // FSM outputs; reset gates both so nothing is accepted or cleared on a reset edge
    always_comb begin
        req_ready_s = 1'b0;
        clr_we_s    = 1'b0;
        case (state_q)
            ST_INIT:  clr_we_s    = !rst_i;
            ST_READY: req_ready_s = !rst_i;
            default: begin
                req_ready_s = 1'b0;
                clr_we_s    = 1'b0;
            end
        endcase
    end

    assign fire_s = mem_if.req_valid & req_ready_s;
    assign lane_s = mem_if.req_addr[1:0];
    assign idx_s  = mem_if.req_addr[IDX_W+1:2];

    // Request legality: funct3 per direction, natural alignment, address range
    always_comb begin
        case (mem_if.req_funct3)
            3'b000, 3'b001, 3'b010: legal_s = 1'b1;
            3'b100, 3'b101:         legal_s = !mem_if.req_we;
            default:                legal_s = 1'b0;
        endcase
        case (mem_if.req_funct3[1:0])
            2'b01:   misalign_s = lane_s[0];
            2'b10:   misalign_s = (lane_s != 2'b00);
            default: misalign_s = 1'b0;
        endcase
        out_of_range_s = |mem_if.req_addr[31:IDX_W+2];
        err_s          = !legal_s | misalign_s | out_of_range_s;
    end

    // Store lane replication and byte enables
    always_comb begin
        case (mem_if.req_funct3[1:0])
            2'b00: begin
                be_s        = 4'b0001 << lane_s;
                wdata_rep_s = {4{mem_if.req_wdata[7:0]}};
            end
            2'b01: begin
                be_s        = lane_s[1] ? 4'b1100 : 4'b0011;
                wdata_rep_s = {2{mem_if.req_wdata[15:0]}};
            end
            2'b10: begin
                be_s        = 4'b1111;
                wdata_rep_s = mem_if.req_wdata;
            end
            default: begin
                be_s        = 4'b0000;
                wdata_rep_s = mem_if.req_wdata;
            end
        endcase
        wr_en_s = fire_s & mem_if.req_we & !err_s;
    end

    // Memory array: sweep writes while initialising, byte-enabled stores afterwards
    always_ff @(posedge clk_i) begin
        if (clr_we_s) begin
            mem_q[clr_idx_q] <= 32'h0000_0000;
        end else if (wr_en_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_q[idx_s][8*b +: 8] <= wdata_rep_s[8*b +: 8];
                end
            end
        end
    end

    // Load lane selection and sign/zero extension ahead of the first response stage
    always_comb begin
        rd_word_s = mem_q[idx_s];
        rd_byte_s = rd_word_s[{lane_s, 3'b000} +: 8];
        rd_half_s = lane_s[1] ? rd_word_s[31:16] : rd_word_s[15:0];
        case (mem_if.req_funct3)
            3'b000:  ext_s = {{24{rd_byte_s[7]}}, rd_byte_s};
            3'b001:  ext_s = {{16{rd_half_s[15]}}, rd_half_s};
            3'b010:  ext_s = rd_word_s;
            3'b100:  ext_s = {24'h00_0000, rd_byte_s};
            3'b101:  ext_s = {16'h0000, rd_half_s};
            default: ext_s = 32'h0000_0000;
        endcase
        if (fire_s && !mem_if.req_we && !err_s) begin
            load_data_s = ext_s;
        end else begin
            load_data_s = 32'h0000_0000;
        end
    end

    // Response pipeline: stage 0 captures the read, later stages only delay it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                rsp_data_q[k] <= 32'h0000_0000;
            end
        end else begin
            rsp_valid_q[0] <= fire_s;
            rsp_err_q[0]   <= fire_s & err_s;
            rsp_data_q[0]  <= load_data_s;
            for (int k = 1; k < READ_LATENCY; k++) begin
                rsp_valid_q[k] <= rsp_valid_q[k-1];
                rsp_err_q[k]   <= rsp_err_q[k-1];
                rsp_data_q[k]  <= rsp_data_q[k-1];
            end
        end
    end

    assign mem_if.req_ready = req_ready_s;
    assign mem_if.rsp_valid = rsp_valid_q[READ_LATENCY-1];
    assign mem_if.rsp_err   = rsp_err_q[READ_LATENCY-1];
    assign mem_if.rsp_rdata = rsp_data_q[READ_LATENCY-1];
endmodule

// File: tb/tb_data_memory_ls.sv
// Directed bench for data_memory_ls: three instances cover the clearing sweep (A),
// a three-cycle latency (B) and a four-cycle latency with mid-flight reset (C).
module tb_data_memory_ls;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, rst_c;
    logic        req_valid_v, req_we_v;
    logic [31:0] req_addr_v, req_wdata_v;
    logic [2:0]  req_funct3_v;
    int          sel = 0;
    int          cyc = 0;
    int          n_pass = 0;
    int          n_checks = 0;

    logic        rdy_m, rv_m, re_m;
    logic [31:0] rd_m;

    logic [31:0] rq_data [$];
    logic        rq_err  [$];
    int          rq_cyc  [$];

    data_memory_ls_if if_a ();
    data_memory_ls_if if_b ();
    data_memory_ls_if if_c ();

    assign if_a.req_valid  = req_valid_v && (sel == 0);
    assign if_a.req_we     = req_we_v;
    assign if_a.req_addr   = req_addr_v;
    assign if_a.req_funct3 = req_funct3_v;
    assign if_a.req_wdata  = req_wdata_v;
    assign if_b.req_valid  = req_valid_v && (sel == 1);
    assign if_b.req_we     = req_we_v;
    assign if_b.req_addr   = req_addr_v;
    assign if_b.req_funct3 = req_funct3_v;
    assign if_b.req_wdata  = req_wdata_v;
    assign if_c.req_valid  = req_valid_v && (sel == 2);
    assign if_c.req_we     = req_we_v;
    assign if_c.req_addr   = req_addr_v;
    assign if_c.req_funct3 = req_funct3_v;
    assign if_c.req_wdata  = req_wdata_v;

    data_memory_ls #(.DEPTH_WORDS(128), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1))
        u_dut_a (.clk_i(clk), .rst_i(rst_a), .mem_if(if_a));
    data_memory_ls #(.DEPTH_WORDS(128), .READ_LATENCY(3), .CLEAR_ON_RESET(1'b0))
        u_dut_b (.clk_i(clk), .rst_i(rst_b), .mem_if(if_b));
    data_memory_ls #(.DEPTH_WORDS(128), .READ_LATENCY(4), .CLEAR_ON_RESET(1'b0))
        u_dut_c (.clk_i(clk), .rst_i(rst_c), .mem_if(if_c));

    always_comb begin
        case (sel)
            0: begin rdy_m = if_a.req_ready; rv_m = if_a.rsp_valid; re_m = if_a.rsp_err; rd_m = if_a.rsp_rdata; end
            1: begin rdy_m = if_b.req_ready; rv_m = if_b.rsp_valid; re_m = if_b.rsp_err; rd_m = if_b.rsp_rdata; end
            default: begin rdy_m = if_c.req_ready; rv_m = if_c.rsp_valid; re_m = if_c.rsp_err; rd_m = if_c.rsp_rdata; end
        endcase
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Response collector for the selected instance
    always @(negedge clk) begin
        if (rv_m) begin
            rq_data.push_back(rd_m);
            rq_err.push_back(re_m);
            rq_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output int acc);
        int g = 0;
        req_valid_v = 1'b1; req_we_v = we; req_funct3_v = f3; req_addr_v = addr; req_wdata_v = wd;
        while (!rdy_m && g < 300) begin @(posedge clk); #1; g++; end
        if (!rdy_m) check("req_ready_wait", {31'b0, rdy_m}, 32'd1);
        @(posedge clk); #1;
        acc = cyc;
    endtask

    task automatic idle();
        req_valid_v = 1'b0;
    endtask

    task automatic get(output logic [31:0] d, output logic e, output int c);
        int g = 0;
        while (rq_data.size() == 0 && g < 40) begin @(negedge clk); g++; end
        check("rsp_seen", {31'b0, rq_data.size() != 0}, 32'd1);
        if (rq_data.size() != 0) begin
            d = rq_data.pop_front(); e = rq_err.pop_front(); c = rq_cyc.pop_front();
        end else begin
            d = 32'hxxxx_xxxx; e = 1'bx; c = -1;
        end
    endtask

    task automatic xact(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e);
        int acc, c;
        logic [31:0] d;
        logic e;
        send(we, f3, addr, wd, acc);
        idle();
        get(d, e, c);
        check({tag, "_data"}, d, exp_d);
        check({tag, "_err"}, {31'b0, e}, {31'b0, exp_e});
    endtask

    task automatic count_sweep(input string tag);
        int cnt = 0;
        for (int g = 0; g < 400 && !rdy_m; g++) begin cnt++; @(posedge clk); #1; end
        check(tag, cnt, 32'd128);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
        $fatal(1);
    end

    initial begin
        int acc0, acc, c;
        logic [31:0] d;
        logic e;

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        req_valid_v = 1'b0; req_we_v = 1'b0; req_addr_v = 32'h0; req_wdata_v = 32'h0; req_funct3_v = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, rdy_m}, 32'd0);
        check("rst_rsp_valid", {31'b0, rv_m}, 32'd0);
        check("rst_rsp_rdata", rd_m, 32'd0);
        check("rst_rsp_err", {31'b0, re_m}, 32'd0);

        // Instance A: clearing sweep, preload, re-sweep
        rst_a = 1'b0;
        count_sweep("sweep1_len");
        xact("preload_sw", 1'b1, 3'b010, 32'h1FC, 32'hDEAD_BEEF, 32'h0, 1'b0);
        xact("preload_lw", 1'b0, 3'b010, 32'h1FC, 32'h0, 32'hDEAD_BEEF, 1'b0);
        rst_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst2_ready", {31'b0, rdy_m}, 32'd0);
        rst_a = 1'b0;
        count_sweep("sweep2_len");
        xact("cleared_lw", 1'b0, 3'b010, 32'h1FC, 32'h0, 32'h0, 1'b0);

        // Byte lanes
        xact("sw0", 1'b1, 3'b010, 32'h0, 32'h1122_3344, 32'h0, 1'b0);
        xact("sb2", 1'b1, 3'b000, 32'h2, 32'h0000_00AB, 32'h0, 1'b0);
        xact("sh0", 1'b1, 3'b001, 32'h0, 32'h0000_BEEF, 32'h0, 1'b0);
        xact("lw0", 1'b0, 3'b010, 32'h0, 32'h0, 32'h11AB_BEEF, 1'b0);
        xact("lb2", 1'b0, 3'b000, 32'h2, 32'h0, 32'hFFFF_FFAB, 1'b0);
        xact("lbu2", 1'b0, 3'b100, 32'h2, 32'h0, 32'h0000_00AB, 1'b0);
        xact("lh0", 1'b0, 3'b001, 32'h0, 32'h0, 32'hFFFF_BEEF, 1'b0);
        xact("lhu0", 1'b0, 3'b101, 32'h0, 32'h0, 32'h0000_BEEF, 1'b0);
        xact("lh2", 1'b0, 3'b001, 32'h2, 32'h0, 32'h0000_11AB, 1'b0);
        xact("lb3", 1'b0, 3'b000, 32'h3, 32'h0, 32'h0000_0011, 1'b0);
        xact("sb_last", 1'b1, 3'b000, 32'h1FF, 32'h0000_0080, 32'h0, 1'b0);
        xact("lb_last", 1'b0, 3'b000, 32'h1FF, 32'h0, 32'hFFFF_FF80, 1'b0);

        // Errors
        xact("lw_mis", 1'b0, 3'b010, 32'h2, 32'h0, 32'h0, 1'b1);
        xact("sh_mis", 1'b1, 3'b001, 32'h3, 32'h0000_5555, 32'h0, 1'b1);
        xact("lw_after_shmis", 1'b0, 3'b010, 32'h0, 32'h0, 32'h11AB_BEEF, 1'b0);
        xact("lw_oor", 1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 1'b1);
        xact("sb_oor", 1'b1, 3'b000, 32'h8000_0000, 32'h0000_0011, 32'h0, 1'b1);
        xact("ld_f3_011", 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1);
        xact("ld_f3_110", 1'b0, 3'b110, 32'h0, 32'h0, 32'h0, 1'b1);
        xact("st_f3_100", 1'b1, 3'b100, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1);
        xact("lw_after_stbad", 1'b0, 3'b010, 32'h0, 32'h0, 32'h11AB_BEEF, 1'b0);

        // Store followed immediately by a load of the same word
        send(1'b1, 3'b010, 32'h10, 32'hCAFE_F00D, acc);
        send(1'b0, 3'b010, 32'h10, 32'h0, acc);
        idle();
        get(d, e, c);
        check("fwd_store_rdata", d, 32'h0);
        get(d, e, c);
        check("fwd_load_rdata", d, 32'hCAFE_F00D);

        // Instance B: latency 3, back-to-back loads
        sel = 1;
        rst_b = 1'b0;
        for (int i = 0; i < 8; i++)
            xact("b_fill", 1'b1, 3'b010, 32'h40 + 32'(4*i), 32'hA500_0000 + 32'(i * 32'h0001_0101), 32'h0, 1'b0);
        send(1'b0, 3'b010, 32'h40, 32'h0, acc0);
        for (int i = 1; i < 8; i++) send(1'b0, 3'b010, 32'h40 + 32'(4*i), 32'h0, acc);
        idle();
        for (int i = 0; i < 8; i++) begin
            get(d, e, c);
            check("b2b_data", d, 32'hA500_0000 + 32'(i * 32'h0001_0101));
            check("b2b_cycle", 32'(c), 32'(acc0 + 2 + i));
        end

        // Instance C: latency 4, reset with loads in flight
        sel = 2;
        rst_c = 1'b0;
        xact("c_sw0", 1'b1, 3'b010, 32'h0, 32'h55AA_55AA, 32'h0, 1'b0);
        xact("c_sw4", 1'b1, 3'b010, 32'h4, 32'h1234_5678, 32'h0, 1'b0);
        send(1'b0, 3'b010, 32'h0, 32'h0, acc);
        send(1'b0, 3'b010, 32'h4, 32'h0, acc);
        send(1'b0, 3'b010, 32'h0, 32'h0, acc);
        req_we_v = 1'b1; req_funct3_v = 3'b010; req_addr_v = 32'h0; req_wdata_v = 32'hFFFF_FFFF;
        rst_c = 1'b1;
        @(posedge clk); #1;
        check("midflight_rv_after_rst", {31'b0, rv_m}, 32'd0);
        check("midflight_ready_in_rst", {31'b0, rdy_m}, 32'd0);
        @(posedge clk); #1;
        rst_c = 1'b0;
        idle();
        repeat (8) @(posedge clk);
        #1;
        check("midflight_no_rsp", 32'(rq_data.size()), 32'd0);
        xact("c_lw0", 1'b0, 3'b010, 32'h0, 32'h0, 32'h55AA_55AA, 1'b0);
        xact("c_lw4", 1'b0, 3'b010, 32'h4, 32'h0, 32'h1234_5678, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
